// File: rtl/noc_flit_pkg.sv
// Flit format constants, tail decode helper and arbiter state type shared by
// the fabric-port shims.
package noc_flit_pkg;

  localparam int unsigned FLIT_W         = 600;
  localparam int unsigned SUBFLIT_W      = FLIT_W / 4;
  localparam int unsigned FLIT_VALID_BIT = FLIT_W - 1;
  localparam int unsigned FLIT_HEAD_BIT  = FLIT_W - 2;
  localparam int unsigned FLIT_TAIL_BIT0 = FLIT_W - 3;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Any sub-flit tail bit marks the flit as the end of a packet.
  function automatic logic flit_is_tail(input logic [FLIT_W-1:0] flit);
    logic t;
    t = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      t = t | flit[FLIT_TAIL_BIT0 - k * SUBFLIT_W];
    end
    return t;
  endfunction

endpackage

// File: rtl/noc_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or above
// ptr_i, wrapping around, as a one-hot vector.
//   req_i  - request vector
//   ptr_i  - index with highest priority this cycle
//   gnt_o  - one-hot grant (zero when no request)
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  // Scan NUM_REQ positions starting at the pointer; first hit wins.
  always_comb begin
    logic        found;
    int unsigned idx;
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr_i) + i) % NUM_REQ;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_port_arbiter.sv
// Packet-atomic round-robin arbiter sharing one fabric input port among
// NUM_REQ requesters, with a single registered ready/valid output stage.
//   clk, reset     - clock, synchronous active-high reset
//   i_data_in      - flattened per-requester flits (requester k at k*NOC_WIDTH)
//   i_valid_in     - per-requester flit valid
//   i_ready_out    - per-requester accept (combinational)
//   o_data_out     - registered flit to the fabric port
//   o_valid_out    - registered output valid
//   o_ready_in     - fabric port ready
//   o_grant        - one-hot lock owner, zero when idle
//   o_pkt_count    - packets forwarded (counted on tail)
//   o_err_framing  - one-cycle pulse after a framing violation is accepted
module noc_port_arbiter
  import noc_flit_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned NOC_WIDTH = 600,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ*NOC_WIDTH-1:0]   i_data_in,
  input  logic [NUM_REQ-1:0]             i_valid_in,
  output logic [NUM_REQ-1:0]             i_ready_out,
  output logic [NOC_WIDTH-1:0]           o_data_out,
  output logic                           o_valid_out,
  input  logic                           o_ready_in,
  output logic [NUM_REQ-1:0]             o_grant,
  output logic [CNT_WIDTH-1:0]           o_pkt_count,
  output logic                           o_err_framing
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  arb_state_t           state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [NOC_WIDTH-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic                 load_en_c;
  logic                 accept_c;
  logic [NUM_REQ-1:0]   rr_gnt_c;
  logic [NUM_REQ-1:0]   owner_oh_c;
  logic [NUM_REQ-1:0]   sel_c;
  logic [PTR_W-1:0]     sel_idx_c;
  logic [NOC_WIDTH-1:0] acc_data_c;
  logic [FLIT_W-1:0]    flit_c;
  logic                 is_head_c;
  logic                 is_tail_c;
  logic                 is_fv_c;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
    return (32'(idx) == NUM_REQ - 1) ? '0 : idx + PTR_W'(1);
  endfunction

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req_i (i_valid_in),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt_c)
  );

  // Output stage can take a new flit when empty or draining this cycle.
  assign load_en_c  = !valid_q | o_ready_in;
  assign owner_oh_c = NUM_REQ'(1) << owner_q;
  assign sel_c      = (state_q == LOCKED) ? (owner_oh_c & i_valid_in) : rr_gnt_c;
  assign accept_c   = load_en_c & (|sel_c) & !reset;
  assign i_ready_out = reset ? '0 : (sel_c & {NUM_REQ{load_en_c}});

  // One-hot select mux and index encode of the accepted requester.
  always_comb begin
    acc_data_c = '0;
    sel_idx_c  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (sel_c[k]) begin
        acc_data_c = acc_data_c | i_data_in[k*NOC_WIDTH +: NOC_WIDTH];
        sel_idx_c  = PTR_W'(k);
      end
    end
  end

  assign flit_c    = FLIT_W'(acc_data_c);
  assign is_fv_c   = flit_c[FLIT_VALID_BIT];
  assign is_head_c = flit_c[FLIT_HEAD_BIT];
  assign is_tail_c = flit_is_tail(flit_c);

  // Next-state: output stage, lock FSM, pointer, counter and framing check.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;

    if (load_en_c) begin
      valid_d = accept_c;
      if (accept_c) begin
        data_d = acc_data_c;
      end
    end

    if (accept_c) begin
      // Missing head in IDLE or stray head in LOCKED is flagged but the flit
      // is still framed by the current state (IDLE = head, LOCKED = body).
      err_d = !is_fv_c | ((state_q == IDLE) ? !is_head_c : is_head_c);
      if (state_q == IDLE) begin
        if (is_tail_c) begin
          ptr_d = next_ptr(sel_idx_c);
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end else begin
          state_d = LOCKED;
          owner_d = sel_idx_c;
        end
      end else if (is_tail_c) begin
        state_d = IDLE;
        ptr_d   = next_ptr(owner_q);
        cnt_d   = cnt_q + CNT_WIDTH'(1);
      end
    end

    grant_d = (state_d == LOCKED) ? (NUM_REQ'(1) << owner_d) : '0;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      grant_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign o_data_out    = data_q;
  assign o_valid_out   = valid_q;
  assign o_grant       = grant_q;
  assign o_pkt_count   = cnt_q;
  assign o_err_framing = err_q;

endmodule
